// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: captures one decoded RV32I instruction,
// resolves forwarding and operand selection, and holds registered ALU
// operands/control under a valid/ready handshake.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            fwd_ex_valid,
  input  logic [4:0]      fwd_ex_rd,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_ctrl,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam int unsigned CTRL_W = 5;
  localparam int unsigned REG_W  = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CTRL_W-1:0] ALU_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_AND  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_OR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_XOR  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_SLL  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_SRL  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_SRA  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALU_SLT  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_SLTU = CTRL_W'(9);

  // Map funct3 to an ALU code; alt selects SUB/SRA variants.
  function automatic logic [CTRL_W-1:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
      3'b111:  f3_op = ALU_AND;
      3'b110:  f3_op = ALU_OR;
      3'b100:  f3_op = ALU_XOR;
      3'b001:  f3_op = ALU_SLL;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b010:  f3_op = ALU_SLT;
      default: f3_op = ALU_SLTU;
    endcase
  endfunction

  logic            capture;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [CTRL_W-1:0] dec_ctrl;
  logic            dec_a_reg, dec_b_reg, dec_illegal;
  logic            a_reg, b_reg;
  logic [REG_W-1:0] a_idx, b_idx;
  logic            unused_f7;

  assign unused_f7 = ^{in_funct7[6], in_funct7[4:0]};

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Forwarding: zero register, then EX result, then WB write, then register file.
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    if (in_rs1 == '0)                             rs1_val = '0;
    else if (fwd_ex_valid && fwd_ex_rd == in_rs1) rs1_val = fwd_ex_data;
    else if (fwd_wb_valid && fwd_wb_rd == in_rs1) rs1_val = fwd_wb_data;
    if (in_rs2 == '0)                             rs2_val = '0;
    else if (fwd_ex_valid && fwd_ex_rd == in_rs2) rs2_val = fwd_ex_data;
    else if (fwd_wb_valid && fwd_wb_rd == in_rs2) rs2_val = fwd_wb_data;
  end

  // Opcode decode into ALU code and operand sources.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_a_reg   = 1'b0;
    dec_b_reg   = 1'b0;
    dec_illegal = 1'b0;
    case (in_opcode)
      OP_R: begin
        dec_ctrl  = f3_op(in_funct3, in_funct7[5]);
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        dec_a_reg = 1'b1;
        dec_b_reg = 1'b1;
      end
      OP_I: begin
        dec_ctrl  = f3_op(in_funct3, in_funct7[5] && (in_funct3 == 3'b101));
        dec_a     = rs1_val;
        dec_b     = in_imm;
        dec_a_reg = 1'b1;
      end
      OP_LUI: begin
        dec_b = in_imm;
      end
      OP_AUIPC: begin
        dec_a = in_pc;
        dec_b = in_imm;
      end
      OP_LOAD, OP_STORE: begin
        dec_a     = rs1_val;
        dec_b     = in_imm;
        dec_a_reg = 1'b1;
      end
      OP_BRANCH: begin
        case (in_funct3[2:1])
          2'b10:   dec_ctrl = ALU_SLT;
          2'b11:   dec_ctrl = ALU_SLTU;
          default: dec_ctrl = ALU_SUB;
        endcase
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        dec_a_reg = 1'b1;
        dec_b_reg = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Stage register: flush, capture, drain, or hold with WB snoop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= '0;
      out_rd      <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
      a_reg       <= 1'b0;
      b_reg       <= 1'b0;
      a_idx       <= '0;
      b_idx       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      alu_a       <= dec_a;
      alu_b       <= dec_b;
      alu_ctrl    <= dec_ctrl;
      out_rd      <= in_rd;
      out_pc      <= in_pc;
      out_illegal <= dec_illegal;
      a_reg       <= dec_a_reg;
      b_reg       <= dec_b_reg;
      a_idx       <= in_rs1;
      b_idx       <= in_rs2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (fwd_wb_valid && fwd_wb_rd != '0 && a_reg && fwd_wb_rd == a_idx) alu_a <= fwd_wb_data;
      if (fwd_wb_valid && fwd_wb_rd != '0 && b_reg && fwd_wb_rd == b_idx) alu_b <= fwd_wb_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a
// randomized stream checked against a transaction-level model.
module tb_alu_issue_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic [6:0]      in_funct7;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic            fwd_ex_valid, fwd_wb_valid;
  logic [4:0]      fwd_ex_rd, fwd_wb_rd;
  logic [XLEN-1:0] fwd_ex_data, fwd_wb_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a, alu_b, out_pc;
  logic [4:0]      alu_ctrl, out_rd;
  logic            out_illegal;

  int n_cmp = 0;
  int n_fail = 0;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc),
    .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Advance one full cycle; returns just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [31:0] pc);
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_pc = pc;
  endtask

  task automatic clear_fwd();
    fwd_ex_valid = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; out_ready = 1; in_valid = 1;
    clear_fwd();
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 32'h100);
    step(); step();
    n_cmp++;
    if ({out_valid, alu_a, alu_b, alu_ctrl, out_rd, out_pc, out_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0d a=%h b=%h c=%0d rd=%0d pc=%h ill=%0d want all 0",
               out_valid, alu_a, alu_b, alu_ctrl, out_rd, out_pc, out_illegal);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0d want 1", in_ready);
    end
    rst = 0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_valid: got %0d want 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || alu_a !== 32'h1 || alu_b !== 32'h2) begin
      n_fail++; $display("FAIL first_capture: got v=%0d a=%h b=%h want v=1 a=1 b=2", out_valid, alu_a, alu_b);
    end
  endtask

  task automatic test_decode();
    in_valid = 1; out_ready = 1;
    set_instr(7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd0, 32'h200);
    step();
    n_cmp++;
    if (alu_ctrl !== 5'd1 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      n_fail++; $display("FAIL r_sub: got c=%0d a=%h b=%h want c=1 a=5 b=7", alu_ctrl, alu_a, alu_b);
    end
    set_instr(7'b0010011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 32'd5, 32'd9, 32'd7, 32'h204);
    step();
    n_cmp++;
    if (alu_ctrl !== 5'd0 || alu_b !== 32'd7 || alu_a !== 32'd5) begin
      n_fail++; $display("FAIL addi_not_sub: got c=%0d a=%h b=%h want c=0 a=5 b=7", alu_ctrl, alu_a, alu_b);
    end
    set_instr(7'b0010011, 3'b101, 7'h20, 5'd1, 5'd0, 5'd4, 32'hF0, 32'd0, 32'd3, 32'h208);
    step();
    n_cmp++;
    if (alu_ctrl !== 5'd7 || alu_b !== 32'd3) begin
      n_fail++; $display("FAIL srai: got c=%0d b=%h want c=7 b=3", alu_ctrl, alu_b);
    end
    set_instr(7'b0010011, 3'b101, 7'h00, 5'd1, 5'd0, 5'd4, 32'hF0, 32'd0, 32'd3, 32'h20C);
    step();
    n_cmp++;
    if (alu_ctrl !== 5'd6) begin
      n_fail++; $display("FAIL srli: got c=%0d want 6", alu_ctrl);
    end
    set_instr(7'b0110111, 3'd0, 7'd0, 5'd1, 5'd2, 5'd4, 32'hDEAD, 32'hBEEF, 32'h12345000, 32'h210);
    step();
    n_cmp++;
    if (alu_a !== 32'd0 || alu_b !== 32'h12345000 || alu_ctrl !== 5'd0 || out_pc !== 32'h210) begin
      n_fail++; $display("FAIL lui: got a=%h b=%h c=%0d pc=%h want a=0 b=12345000 c=0 pc=210", alu_a, alu_b, alu_ctrl, out_pc);
    end
  endtask

  task automatic test_forwarding();
    in_valid = 1; out_ready = 1;
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 32'h11, 32'h44, 32'd0, 32'h300);
    fwd_ex_valid = 1; fwd_ex_rd = 3; fwd_ex_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 3; fwd_wb_data = 32'hBB;
    step();
    n_cmp++;
    if (alu_a !== 32'hAA || alu_b !== 32'h44) begin
      n_fail++; $display("FAIL fwd_ex_wins: got a=%h b=%h want a=aa b=44", alu_a, alu_b);
    end
    fwd_ex_valid = 0;
    step();
    n_cmp++;
    if (alu_a !== 32'hBB) begin
      n_fail++; $display("FAIL fwd_wb: got a=%h want bb", alu_a);
    end
    in_rs1 = 0; in_rs1_data = 32'h11;
    fwd_ex_valid = 1; fwd_ex_rd = 0; fwd_wb_rd = 0;
    step();
    n_cmp++;
    if (alu_a !== 32'h0) begin
      n_fail++; $display("FAIL fwd_x0: got a=%h want 0", alu_a);
    end
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    in_valid = 1; out_ready = 1;
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd5, 32'd10, 32'd20, 32'd0, 32'h400);
    step();
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd6, 5'd7, 5'd9, 32'h66, 32'h77, 32'd0, 32'h404);
    out_ready = 0;
    fwd_ex_valid = 1; fwd_ex_rd = 1; fwd_ex_data = 32'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_in_ready: cycle %0d got %0d want 0", i, in_ready);
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || alu_a !== 32'd10 || alu_b !== 32'd20 || out_rd !== 5'd5) begin
        n_fail++; $display("FAIL hold_stable: cycle %0d got v=%0d a=%h b=%h rd=%0d want v=1 a=a b=14 rd=5",
                           i, out_valid, alu_a, alu_b, out_rd);
      end
    end
    fwd_ex_valid = 0;
    fwd_wb_valid = 1; fwd_wb_rd = 2; fwd_wb_data = 32'h55;
    step();
    fwd_wb_valid = 0;
    n_cmp++;
    if (alu_b !== 32'h55 || alu_a !== 32'd10) begin
      n_fail++; $display("FAIL hold_snoop: got a=%h b=%h want a=a b=55", alu_a, alu_b);
    end
    out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %0d want 1", in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || alu_a !== 32'h66 || alu_b !== 32'h77 || out_rd !== 5'd9) begin
      n_fail++; $display("FAIL release_next: got v=%0d a=%h b=%h rd=%0d want v=1 a=66 b=77 rd=9", out_valid, alu_a, alu_b, out_rd);
    end
    in_rs1_data = 32'h123;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || alu_a !== 32'h123) begin
      n_fail++; $display("FAIL no_bubble: got v=%0d a=%h want v=1 a=123", out_valid, alu_a);
    end
    in_valid = 0;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain: got v=%0d want 0", out_valid);
    end
  endtask

  task automatic test_flush_illegal();
    in_valid = 1; out_ready = 1; flush = 1;
    set_instr(7'b0110011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 32'd0, 32'h500);
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_capture: got v=%0d want 0", out_valid);
    end
    flush = 0;
    set_instr(7'h7F, 3'd3, 7'h20, 5'd1, 5'd2, 5'd8, 32'h99, 32'h98, 32'h97, 32'h504);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || alu_ctrl !== 5'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      n_fail++; $display("FAIL illegal: got v=%0d ill=%0d c=%0d a=%h b=%h want v=1 ill=1 c=0 a=0 b=0",
                         out_valid, out_illegal, alu_ctrl, alu_a, alu_b);
    end
    in_valid = 0; out_ready = 0; flush = 1;
    step();
    flush = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold: got v=%0d want 0", out_valid);
    end
    out_ready = 1;
  endtask

  // Reference model of the instruction's ALU function and operand sources.
  // a_kind: 0 zero, 1 rs1, 2 pc.  b_kind: 0 zero, 1 rs2, 2 imm.
  function automatic void model_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                       output int ctrl, output int a_kind, output int b_kind, output bit ill);
    int base [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    ctrl = 0; a_kind = 0; b_kind = 0; ill = 0;
    if (op == 7'h33) begin
      ctrl = base[f3] + ((f7[5] && (f3 == 0 || f3 == 5)) ? 1 : 0);
      a_kind = 1; b_kind = 1;
    end else if (op == 7'h13) begin
      ctrl = base[f3] + ((f7[5] && f3 == 5) ? 1 : 0);
      a_kind = 1; b_kind = 2;
    end else if (op == 7'h37) begin
      b_kind = 2;
    end else if (op == 7'h17) begin
      a_kind = 2; b_kind = 2;
    end else if (op == 7'h03 || op == 7'h23) begin
      a_kind = 1; b_kind = 2;
    end else if (op == 7'h63) begin
      ctrl = (f3 < 2) ? 1 : ((f3 < 6) ? 8 : 9);
      a_kind = 1; b_kind = 1;
    end else begin
      ill = 1;
    end
  endfunction

  function automatic logic [31:0] model_reg(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (fwd_ex_valid && fwd_ex_rd == idx) return fwd_ex_data;
    if (fwd_wb_valid && fwd_wb_rd == idx) return fwd_wb_data;
    return rf;
  endfunction

  task automatic test_random();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h7F, 7'h6F};
    logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    bit mv; logic [31:0] ma, mb, mpc; int mctrl; logic [4:0] mrd; bit mill;
    bit m_areg, m_breg; logic [4:0] m_aidx, m_bidx;
    int ctrl, ak, bk; bit ill;
    int bad_ready = 0, bad_data = 0;
    rst = 1; in_valid = 0; flush = 0; clear_fwd();
    step();
    rst = 0;
    mv = 0; ma = 0; mb = 0; mpc = 0; mctrl = 0; mrd = 0; mill = 0;
    m_areg = 0; m_breg = 0; m_aidx = 0; m_bidx = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++;
      if (out_valid !== mv ||
          (mv && {alu_a, alu_b, alu_ctrl, out_rd, out_pc, out_illegal} !== {ma, mb, 5'(mctrl), mrd, mpc, mill})) begin
        n_fail++;
        if (bad_data++ < 8)
          $display("FAIL random_out cyc %0d: got v=%0d a=%h b=%h c=%0d rd=%0d pc=%h ill=%0d want v=%0d a=%h b=%h c=%0d rd=%0d pc=%h ill=%0d",
                   cyc, out_valid, alu_a, alu_b, alu_ctrl, out_rd, out_pc, out_illegal,
                   mv, ma, mb, mctrl, mrd, mpc, mill);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_opcode = ops[$urandom_range(0, 8)];
      in_funct3 = 3'($urandom_range(0, 7));
      if (in_opcode == 7'h63) in_funct3 = br_f3[$urandom_range(0, 5)];
      in_funct7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_rd  = 5'($urandom);
      in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom; in_pc = $urandom;
      fwd_ex_valid = $urandom_range(0, 1); fwd_ex_rd = 5'($urandom_range(0, 7)); fwd_ex_data = $urandom;
      fwd_wb_valid = $urandom_range(0, 1); fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
      #1;
      n_cmp++;
      if (in_ready !== (!mv || out_ready)) begin
        n_fail++;
        if (bad_ready++ < 8) $display("FAIL random_in_ready cyc %0d: got %0d want %0d", cyc, in_ready, (!mv || out_ready));
      end
      if (flush) begin
        mv = 0;
      end else if (in_valid && (!mv || out_ready)) begin
        model_decode(in_opcode, in_funct3, in_funct7, ctrl, ak, bk, ill);
        mv = 1; mctrl = ctrl; mill = ill; mrd = in_rd; mpc = in_pc;
        ma = (ak == 1) ? model_reg(in_rs1, in_rs1_data) : (ak == 2) ? in_pc : 32'd0;
        mb = (bk == 1) ? model_reg(in_rs2, in_rs2_data) : (bk == 2) ? in_imm : 32'd0;
        m_areg = (ak == 1); m_breg = (bk == 1); m_aidx = in_rs1; m_bidx = in_rs2;
      end else if (mv && out_ready) begin
        mv = 0;
      end else if (mv) begin
        if (fwd_wb_valid && fwd_wb_rd != 0 && m_areg && fwd_wb_rd == m_aidx) ma = fwd_wb_data;
        if (fwd_wb_valid && fwd_wb_rd != 0 && m_breg && fwd_wb_rd == m_bidx) mb = fwd_wb_data;
      end
      @(negedge clk);
    end
    in_valid = 0; flush = 0; clear_fwd();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_decode();
    test_forwarding();
    test_back_to_back();
    test_flush_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
